// File: rtl/noc_output_allocator_if.sv
// noc_output_allocator_if: request/grant/credit bundle between the input ports and one output allocator
interface noc_output_allocator_if #(parameter int TO_W = 12);
  logic [4:0] req;
  logic [4:0] tail;
  logic credit_in;
  logic [TO_W-1:0] timeout_len;
  logic [4:0] grant;
  logic xfer;
  logic [2:0] credit_cnt;
  logic timesup;
  logic err;
  modport master(output req, tail, credit_in, timeout_len, input grant, xfer, credit_cnt, timesup, err);
  modport slave(input req, tail, credit_in, timeout_len, output grant, xfer, credit_cnt, timesup, err);
endinterface

// File: rtl/noc_output_allocator.sv
// noc_output_allocator: packet-level round-robin output allocator with credits; stall watchdog built when NOC_ALLOC_TIMEOUT_EN is defined
module noc_output_allocator #(
  parameter int CREDITS = 4,
  parameter int TO_W = 12
) (
  input logic clk,
  input logic rst,
  noc_output_allocator_if.slave bus
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t st;
  logic [2:0] own, rr, pick, idx, nxt, cnt;
  logic [3:0] s;
  logic [4:0] grant;
  logic xfer, to_hit, ts, err;
  assign nxt = own == 3'd4 ? 3'd0 : own + 3'd1;
  assign xfer = st == BUSY && bus.req[own] && cnt != 3'd0;
  assign bus.grant = grant;
  assign bus.xfer = xfer;
  assign bus.credit_cnt = cnt;
  assign bus.timesup = ts;
  assign bus.err = err;
  // first requester at or after rr, wrapping mod 5; descending scan lets the nearest one win
  always_comb begin
    pick = '0;
    s = '0;
    idx = '0;
    for (int k = 4; k >= 0; k--) begin
      s = {1'b0, rr} + 4'(k);
      idx = s >= 4'd5 ? 3'(s - 4'd5) : s[2:0];
      if (bus.req[idx]) pick = idx;
    end
  end
  // grant ownership: held from head until tail transfer or watchdog revoke
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      grant <= '0;
      own <= '0;
      rr <= '0;
    end else if (st == IDLE) begin
      if (|bus.req) begin
        st <= BUSY;
        own <= pick;
        grant <= 5'b1 << pick;
      end
    end else if ((xfer && bus.tail[own]) || to_hit) begin
      st <= IDLE;
      grant <= '0;
      rr <= nxt;
    end
  end
  // downstream credit counter; a return while full is flagged and dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 3'(CREDITS);
      err <= 1'b0;
    end else if (xfer && !bus.credit_in) begin
      cnt <= cnt - 3'd1;
    end else if (bus.credit_in && !xfer) begin
      if (cnt == 3'(CREDITS)) err <= 1'b1;
      else cnt <= cnt + 3'd1;
    end
  end
`ifdef NOC_ALLOC_TIMEOUT_EN
  logic [TO_W-1:0] sc;
  assign to_hit = st == BUSY && !xfer && bus.timeout_len != '0 && sc == bus.timeout_len;
  // stall counter counts granted cycles without a transfer; revoke pulse is registered
  always_ff @(posedge clk) begin
    if (rst || st == IDLE || xfer) sc <= '0;
    else sc <= sc + 1'b1;
    ts <= !rst && to_hit;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^bus.timeout_len;
  assign to_hit = 1'b0;
  assign ts = 1'b0;
`endif
endmodule
